// File: rtl/rps_round_if.sv
// Display handshake between the round controller and the LCD 1602 driver.
// The controller holds disp_req with a stable disp_code until the driver pulses disp_ack.
interface rps_round_if;
  logic       disp_req;
  logic [2:0] disp_code;
  logic       disp_ack;

  modport master (output disp_req, output disp_code, input disp_ack);
  modport slave  (input disp_req, input disp_code, output disp_ack);
endinterface

// File: rtl/rps_round_ctrl.sv
// Rock-paper-scissors match sequencer: latches moves, judges rounds, keeps scores
// and issues one LCD message per event over a req/ack handshake.
module rps_round_ctrl #(
  parameter int unsigned HOLD_CYC  = 50_000_000,
  parameter int unsigned WIN_SCORE = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  A,
  input  logic [3:0]  B,
  rps_round_if.master disp,
  output logic [1:0]  move_a,
  output logic [1:0]  move_b,
  output logic [1:0]  result,
  output logic [3:0]  score_a,
  output logic [3:0]  score_b,
  output logic        match_over
);

  localparam int unsigned CNT_W = (HOLD_CYC < 2) ? 1 : $clog2(HOLD_CYC + 1);
  localparam int unsigned MV_W  = 2;
  localparam int unsigned SC_W  = 4;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((HOLD_CYC == 0) ? 0 : HOLD_CYC - 1);
  localparam logic [SC_W-1:0]  SCORE_WIN = SC_W'(WIN_SCORE);
  localparam logic [SC_W-1:0]  SCORE_MAX = '1;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_A    = 2'b01;
  localparam logic [1:0] RES_B    = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  typedef enum logic [2:0] {
    CODE_READY   = 3'd0,
    CODE_A_ROUND = 3'd1,
    CODE_B_ROUND = 3'd2,
    CODE_DRAW    = 3'd3,
    CODE_A_MATCH = 3'd4,
    CODE_B_MATCH = 3'd5
  } code_e;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_PROMPT  = 4'd1,
    ST_WAIT_MV = 4'd2,
    ST_JUDGE   = 4'd3,
    ST_SHOW    = 4'd4,
    ST_HOLD    = 4'd5,
    ST_RELEASE = 4'd6,
    ST_FINAL   = 4'd7,
    ST_OVER    = 4'd8
  } state_e;

  state_e             state, state_nxt;
  logic               req_q, req_nxt;
  code_e              code_q, code_nxt;
  logic [MV_W-1:0]    move_a_nxt, move_b_nxt;
  logic [1:0]         result_nxt;
  logic [SC_W-1:0]    score_a_nxt, score_b_nxt;
  logic               match_over_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  logic               a_legal, b_legal;
  logic               a_have, b_have;
  logic [1:0]         verdict;

  // 1 rock, 2 scissors, 3 paper; anything else counts as no move
  function automatic logic is_legal(input logic [3:0] mv);
    return (mv == 4'd1) || (mv == 4'd2) || (mv == 4'd3);
  endfunction

  // Each move beats the one numbered one above it, paper wraps onto rock
  function automatic logic [1:0] judge(input logic [MV_W-1:0] a, input logic [MV_W-1:0] b);
    logic [1:0] r;
    r = RES_B;
    if (a == b) begin
      r = RES_DRAW;
    end else if ((a == 2'd1 && b == 2'd2) || (a == 2'd2 && b == 2'd3) ||
                 (a == 2'd3 && b == 2'd1)) begin
      r = RES_A;
    end
    return r;
  endfunction

  assign a_legal = is_legal(A);
  assign b_legal = is_legal(B);
  assign a_have  = (move_a != '0) || a_legal;
  assign b_have  = (move_b != '0) || b_legal;
  assign verdict = judge(move_a, move_b);

  assign disp.disp_req  = req_q;
  assign disp.disp_code = code_q;

  // State and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_q      <= 1'b0;
      code_q     <= CODE_READY;
      move_a     <= '0;
      move_b     <= '0;
      result     <= RES_NONE;
      score_a    <= '0;
      score_b    <= '0;
      match_over <= 1'b0;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      req_q      <= req_nxt;
      code_q     <= code_nxt;
      move_a     <= move_a_nxt;
      move_b     <= move_b_nxt;
      result     <= result_nxt;
      score_a    <= score_a_nxt;
      score_b    <= score_b_nxt;
      match_over <= match_over_nxt;
      cnt        <= cnt_nxt;
    end
  end

  // Next-state and next-output logic; req rises together with its code on state entry
  always_comb begin
    state_nxt      = state;
    req_nxt        = req_q;
    code_nxt       = code_q;
    move_a_nxt     = move_a;
    move_b_nxt     = move_b;
    result_nxt     = result;
    score_a_nxt    = score_a;
    score_b_nxt    = score_b;
    match_over_nxt = match_over;
    cnt_nxt        = cnt;

    unique case (state)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_nxt      = ST_PROMPT;
          req_nxt        = 1'b1;
          code_nxt       = CODE_READY;
          move_a_nxt     = '0;
          move_b_nxt     = '0;
          result_nxt     = RES_NONE;
          score_a_nxt    = '0;
          score_b_nxt    = '0;
          match_over_nxt = 1'b0;
        end
      end

      ST_PROMPT: begin
        if (disp.disp_ack) begin
          req_nxt   = 1'b0;
          state_nxt = ST_WAIT_MV;
        end
      end

      ST_WAIT_MV: begin
        // First legal value wins; an already-latched move is never overwritten
        if (move_a == '0 && a_legal) move_a_nxt = MV_W'(A);
        if (move_b == '0 && b_legal) move_b_nxt = MV_W'(B);
        if (a_have && b_have) state_nxt = ST_JUDGE;
      end

      ST_JUDGE: begin
        result_nxt = verdict;
        req_nxt    = 1'b1;
        state_nxt  = ST_SHOW;
        unique case (verdict)
          RES_A: begin
            code_nxt = CODE_A_ROUND;
            if (score_a != SCORE_MAX) score_a_nxt = score_a + SC_W'(1);
          end
          RES_B: begin
            code_nxt = CODE_B_ROUND;
            if (score_b != SCORE_MAX) score_b_nxt = score_b + SC_W'(1);
          end
          default: code_nxt = CODE_DRAW;
        endcase
      end

      ST_SHOW: begin
        if (disp.disp_ack) begin
          req_nxt   = 1'b0;
          cnt_nxt   = '0;
          state_nxt = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (cnt == CNT_LAST) begin
          if (score_a == SCORE_WIN || score_b == SCORE_WIN) begin
            state_nxt = ST_FINAL;
            req_nxt   = 1'b1;
            code_nxt  = (score_a == SCORE_WIN) ? CODE_A_MATCH : CODE_B_MATCH;
          end else begin
            state_nxt = ST_RELEASE;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_RELEASE: begin
        // Both players must let go, so a held input cannot auto-play the next round
        if (!a_legal && !b_legal) begin
          move_a_nxt = '0;
          move_b_nxt = '0;
          state_nxt  = ST_WAIT_MV;
        end
      end

      ST_FINAL: begin
        if (disp.disp_ack) begin
          req_nxt        = 1'b0;
          match_over_nxt = 1'b1;
          state_nxt      = ST_OVER;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

endmodule
